// File: rtl/gb_cpu_regfile.sv
// GB CPU register file: A,F,B,C,D,E,H,L + SP, two 8-bit read ports, 16-bit pair port and IDU.
// Optional macro GB_CPU_REGFILE_BYPASS_EN forwards same-cycle writes to all read outputs.
module gb_cpu_regfile #(
  parameter logic [15:0] RESET_AF = 16'h01B0,
  parameter logic [15:0] RESET_BC = 16'h0013,
  parameter logic [15:0] RESET_DE = 16'h00D8,
  parameter logic [15:0] RESET_HL = 16'h014D,
  parameter logic [15:0] RESET_SP = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  rd_a_sel,
  output logic [7:0]  rd_a_data,
  input  logic [2:0]  rd_b_sel,
  output logic [7:0]  rd_b_data,
  output logic [3:0]  flags_q,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic        flags_we,
  input  logic [3:0]  flags_d,
  input  logic [1:0]  pair_sel,
  output logic [15:0] pair_rd_data,
  input  logic        pair_wr_en,
  input  logic [15:0] pair_wr_data,
  input  logic [1:0]  idu_op,
  output logic [15:0] hl_q,
  output logic [15:0] sp_q
);

  logic [7:0]  a_reg, b_reg, c_reg, d_reg, e_reg, h_reg, l_reg;
  logic [3:0]  flags_reg;
  logic [15:0] sp_reg;

  logic [7:0]  a_next, b_next, c_next, d_next, e_next, h_next, l_next;
  logic [3:0]  flags_next;
  logic [15:0] sp_next;

  logic [15:0] pair_cur, pair_new;
  logic        pair_act;

  always_comb begin
    case (pair_sel)
      2'd0:    pair_cur = {b_reg, c_reg};
      2'd1:    pair_cur = {d_reg, e_reg};
      2'd2:    pair_cur = {h_reg, l_reg};
      default: pair_cur = sp_reg;
    endcase

    pair_act = pair_wr_en || (idu_op == 2'd1) || (idu_op == 2'd2);
    if (pair_wr_en)
      pair_new = pair_wr_data;
    else if (idu_op == 2'd1)
      pair_new = pair_cur + 16'd1;
    else if (idu_op == 2'd2)
      pair_new = pair_cur - 16'd1;
    else
      pair_new = pair_cur;

    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    e_next     = e_reg;
    h_next     = h_reg;
    l_next     = l_reg;
    flags_next = flags_reg;
    sp_next    = sp_reg;

    // 16-bit result first so a same-cycle 8-bit write can override its byte.
    if (pair_act) begin
      case (pair_sel)
        2'd0:    {b_next, c_next} = pair_new;
        2'd1:    {d_next, e_next} = pair_new;
        2'd2:    {h_next, l_next} = pair_new;
        default: sp_next = pair_new;
      endcase
    end

    if (wr_en) begin
      case (wr_sel)
        3'd0:    b_next = wr_data;
        3'd1:    c_next = wr_data;
        3'd2:    d_next = wr_data;
        3'd3:    e_next = wr_data;
        3'd4:    h_next = wr_data;
        3'd5:    l_next = wr_data;
        3'd6:    flags_next = wr_data[7:4];
        default: a_next = wr_data;
      endcase
    end

    if (flags_we)
      flags_next = flags_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= RESET_AF[15:8];
      flags_reg <= RESET_AF[7:4];
      b_reg     <= RESET_BC[15:8];
      c_reg     <= RESET_BC[7:0];
      d_reg     <= RESET_DE[15:8];
      e_reg     <= RESET_DE[7:0];
      h_reg     <= RESET_HL[15:8];
      l_reg     <= RESET_HL[7:0];
      sp_reg    <= RESET_SP;
    end else begin
      a_reg     <= a_next;
      flags_reg <= flags_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      e_reg     <= e_next;
      h_reg     <= h_next;
      l_reg     <= l_next;
      sp_reg    <= sp_next;
    end
  end

  // View seen by every read output: registered state, or the pending commit when forwarding.
  logic [7:0]  v_a, v_b, v_c, v_d, v_e, v_h, v_l;
  logic [3:0]  v_flags;
  logic [15:0] v_sp;

`ifdef GB_CPU_REGFILE_BYPASS_EN
  // While in reset the pending writes are discarded, so show the reset state.
  assign v_a     = rst_n ? a_next     : a_reg;
  assign v_b     = rst_n ? b_next     : b_reg;
  assign v_c     = rst_n ? c_next     : c_reg;
  assign v_d     = rst_n ? d_next     : d_reg;
  assign v_e     = rst_n ? e_next     : e_reg;
  assign v_h     = rst_n ? h_next     : h_reg;
  assign v_l     = rst_n ? l_next     : l_reg;
  assign v_flags = rst_n ? flags_next : flags_reg;
  assign v_sp    = rst_n ? sp_next    : sp_reg;
`else
  assign v_a     = a_reg;
  assign v_b     = b_reg;
  assign v_c     = c_reg;
  assign v_d     = d_reg;
  assign v_e     = e_reg;
  assign v_h     = h_reg;
  assign v_l     = l_reg;
  assign v_flags = flags_reg;
  assign v_sp    = sp_reg;
`endif

  logic [2:0] rd_sel  [2];
  logic [7:0] rd_data [2];

  assign rd_sel[0] = rd_a_sel;
  assign rd_sel[1] = rd_b_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        case (rd_sel[gi])
          3'd0:    rd_data[gi] = v_b;
          3'd1:    rd_data[gi] = v_c;
          3'd2:    rd_data[gi] = v_d;
          3'd3:    rd_data[gi] = v_e;
          3'd4:    rd_data[gi] = v_h;
          3'd5:    rd_data[gi] = v_l;
          3'd6:    rd_data[gi] = {v_flags, 4'b0000};
          default: rd_data[gi] = v_a;
        endcase
      end
    end
  endgenerate

  assign rd_a_data = rd_data[0];
  assign rd_b_data = rd_data[1];
  assign flags_q   = v_flags;
  assign hl_q      = {v_h, v_l};
  assign sp_q      = v_sp;

  always_comb begin
    case (pair_sel)
      2'd0:    pair_rd_data = {v_b, v_c};
      2'd1:    pair_rd_data = {v_d, v_e};
      2'd2:    pair_rd_data = {v_h, v_l};
      default: pair_rd_data = v_sp;
    endcase
  end

endmodule

// File: tb/tb_gb_cpu_regfile.sv
// Directed testbench for gb_cpu_regfile; honours GB_CPU_REGFILE_BYPASS_EN for the forwarding check.
module tb_gb_cpu_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_a_sel, rd_b_sel, wr_sel;
  logic [7:0]  rd_a_data, rd_b_data, wr_data;
  logic [3:0]  flags_q, flags_d;
  logic        wr_en, flags_we, pair_wr_en;
  logic [1:0]  pair_sel, idu_op;
  logic [15:0] pair_rd_data, pair_wr_data, hl_q, sp_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gb_cpu_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
    .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
    .flags_q(flags_q),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .flags_we(flags_we), .flags_d(flags_d),
    .pair_sel(pair_sel), .pair_rd_data(pair_rd_data),
    .pair_wr_en(pair_wr_en), .pair_wr_data(pair_wr_data),
    .idu_op(idu_op), .hl_q(hl_q), .sp_q(sp_q)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_sel = 3'd0; wr_data = 8'h00;
    flags_we = 1'b0; flags_d = 4'h0;
    pair_wr_en = 1'b0; pair_wr_data = 16'h0000; idu_op = 2'd0;
  endtask

  // Commit on the next rising edge, then move 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pair_write(input logic [1:0] sel, input logic [15:0] val);
    idle();
    pair_sel = sel; pair_wr_en = 1'b1; pair_wr_data = val;
    step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    rd_a_sel = 3'd7; rd_b_sel = 3'd6; pair_sel = 2'd0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("reset_a",     {8'h00, rd_a_data}, 16'h0001);
    check("reset_f",     {8'h00, rd_b_data}, 16'h00B0);
    check("reset_flags", {12'h000, flags_q}, 16'h000B);
    check("reset_bc",    pair_rd_data, 16'h0013);
    check("reset_hl",    hl_q, 16'h014D);
    check("reset_sp",    sp_q, 16'hFFFE);
    pair_sel = 2'd1; #1;
    check("reset_de",    pair_rd_data, 16'h00D8);
    rst_n = 1'b1;
    step();

    // F low nibble masked on an 8-bit write
    wr_en = 1'b1; wr_sel = 3'd6; wr_data = 8'hFF;
    step(); idle();
    rd_a_sel = 3'd6; #1;
    check("fmask_f",     {8'h00, rd_a_data}, 16'h00F0);
    check("fmask_flags", {12'h000, flags_q}, 16'h000F);

    // flags_we beats wr_sel=6
    wr_en = 1'b1; wr_sel = 3'd6; wr_data = 8'h00;
    flags_we = 1'b1; flags_d = 4'b1010;
    step(); idle(); #1;
    check("flagprio_f",  {8'h00, rd_a_data}, 16'h00A0);

    // IDU wrap both directions
    pair_write(2'd3, 16'hFFFF);
    pair_sel = 2'd3; idu_op = 2'd1;
    step(); idle(); #1;
    check("idu_inc_wrap", sp_q, 16'h0000);
    pair_write(2'd0, 16'h0000);
    pair_sel = 2'd0; idu_op = 2'd2;
    step(); idle(); #1;
    check("idu_dec_wrap", pair_rd_data, 16'hFFFF);
    check("idu_f_kept",   {8'h00, rd_a_data}, 16'h00A0);

    // 8-bit write + pair write + IDU on BC
    pair_write(2'd0, 16'h0000);
    pair_sel = 2'd0; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h12;
    pair_wr_en = 1'b1; pair_wr_data = 16'hAAAA; idu_op = 2'd1;
    step(); idle(); #1;
    check("conflict_bc", pair_rd_data, 16'h12AA);

    // pair write wins over IDU
    pair_sel = 2'd1; pair_wr_en = 1'b1; pair_wr_data = 16'h1234; idu_op = 2'd1;
    step(); idle(); #1;
    check("pairwr_over_idu", pair_rd_data, 16'h1234);

    // independent writes in one cycle: A, HL inc, flags
    rd_a_sel = 3'd7; rd_b_sel = 3'd6;
    wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h77;
    pair_sel = 2'd2; idu_op = 2'd1;
    flags_we = 1'b1; flags_d = 4'b0101;
    step(); idle(); #1;
    check("multi_a",  {8'h00, rd_a_data}, 16'h0077);
    check("multi_hl", hl_q, 16'h014E);
    check("multi_f",  {8'h00, rd_b_data}, 16'h0050);

    // 8-bit write to H overrides high byte of IDU dec
    pair_sel = 2'd2; idu_op = 2'd2; wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h80;
    step(); idle(); #1;
    check("h_over_idu", hl_q, 16'h804D);

    // reserved IDU op, and 8-bit write never reaches SP
    pair_sel = 2'd3; idu_op = 2'd3;
    step(); idle(); #1;
    check("idu_reserved_sp", sp_q, 16'h0000);
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 8'h5E;
    step(); idle();
    pair_sel = 2'd1; #1;
    check("wr_e_de", pair_rd_data, 16'h125E);
    check("wr_e_sp", sp_q, 16'h0000);

    // same-cycle read of a write
    rd_a_sel = 3'd7;
    wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h5A;
    #1;
`ifdef GB_CPU_REGFILE_BYPASS_EN
    check("bypass_same", {8'h00, rd_a_data}, 16'h005A);
`else
    check("bypass_same", {8'h00, rd_a_data}, 16'h0077);
`endif
    step(); idle(); #1;
    check("bypass_next", {8'h00, rd_a_data}, 16'h005A);

    // async reset mid-sim with a pending write
    wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h33;
    rst_n = 1'b0; #1;
    pair_sel = 2'd0; #1;
    check("midrst_a",  {8'h00, rd_a_data}, 16'h0001);
    check("midrst_sp", sp_q, 16'hFFFE);
    check("midrst_bc", pair_rd_data, 16'h0013);
    step(); #1;
    check("midrst_a_held", {8'h00, rd_a_data}, 16'h0001);
    check("midrst_f",      {8'h00, rd_b_data}, 16'h00B0);
    idle();
    rst_n = 1'b1;
    step(); #1;
    check("post_rst_hl", hl_q, 16'h014D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
